// File: rtl/lcd_pkg.sv
//==============================================================================
// Module  : lcd_pkg
// Brief   : Shared types and constants for the LCD text sequencer.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package lcd_pkg;

    localparam int LCD_NUM_CHARS = 32;

    // Nibble placement inside a character's two-word slot
    localparam int NIB_LO_OFS = 0;
    localparam int NIB_HI_OFS = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_LO = 3'd1,
        ST_FETCH_HI = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_PRESENT  = 3'd4,
        ST_WR_LO    = 3'd5,
        ST_WR_HI    = 3'd6
    } lcd_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_refresh_timer.sv
//==============================================================================
// Module  : lcd_refresh_timer
// Brief   : Free-running period counter; one-cycle tick on terminal count.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module lcd_refresh_timer #(
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (r_cnt == CNT_W'(REFRESH_CYCLES - 1)) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/lcd_text_sequencer.sv
//==============================================================================
// Module  : lcd_text_sequencer
// Brief   : Streams a frame of nibble-packed characters from BRAM to the LCD
//           engine and slots host writes in between character fetches.
//           Optional periodic refresh: LCD_TEXT_SEQUENCER_AUTO_REFRESH_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module lcd_text_sequencer
    import lcd_pkg::*;
#(
    parameter int  NUM_CHARS      = LCD_NUM_CHARS,
    parameter int  ADDR_W         = 12,
    parameter int  BASE_ADDR      = 0,
    parameter int  REFRESH_CYCLES = 1000000,
    localparam int IDX_W          = idx_width(NUM_CHARS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic [7:0]        char_data,
    output logic [IDX_W-1:0]  char_idx,
    output logic              char_last,
    output logic              char_valid,
    input  logic              char_ready,
    input  logic              wr_req,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [7:0]        wr_char,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [3:0]        bram_di,
    output logic              bram_en,
    output logic              bram_we,
    output logic              bram_ssr,
    input  logic [3:0]        bram_do
);

    lcd_state_t        r_state;
    lcd_state_t        w_state_nxt;
    logic [IDX_W-1:0]  r_k;
    logic              r_busy;
    logic [7:0]        r_char_data;
    logic [IDX_W-1:0]  r_char_idx;
    logic              r_char_last;
    logic              r_char_valid;

    logic              w_auto_start;
    logic              w_start;
    logic              w_accept;
    logic              w_last;
    logic              w_hshake;
    logic [ADDR_W-1:0] w_fetch_base;
    logic [ADDR_W-1:0] w_wr_base;

`ifdef LCD_TEXT_SEQUENCER_AUTO_REFRESH_EN
    lcd_refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (w_auto_start)
    );
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (REFRESH_CYCLES > 0);
    assign w_auto_start = 1'b0;
`endif

    // A start is only taken when no frame is in flight; busy doubles as the
    // pending-start flag when the request collides with a host write.
    assign w_start      = start | w_auto_start;
    assign w_accept     = w_start & ~r_busy;
    assign w_last       = (r_k == IDX_W'(NUM_CHARS - 1));
    assign w_hshake     = (r_state == ST_PRESENT) & char_ready;
    assign w_fetch_base = ADDR_W'(BASE_ADDR) + (ADDR_W'(r_k) << 1);
    assign w_wr_base    = ADDR_W'(BASE_ADDR) + (ADDR_W'(wr_idx) << 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        bram_en     = 1'b0;
        bram_we     = 1'b0;
        bram_addr   = w_fetch_base + ADDR_W'(NIB_LO_OFS);
        bram_di     = 4'h0;
        wr_ack      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wr_req) begin
                    w_state_nxt = ST_WR_LO;
                end else if (w_start) begin
                    w_state_nxt = ST_FETCH_LO;
                end
            end
            ST_FETCH_LO: begin
                bram_en     = 1'b1;
                w_state_nxt = ST_FETCH_HI;
            end
            ST_FETCH_HI: begin
                bram_en     = 1'b1;
                bram_addr   = w_fetch_base + ADDR_W'(NIB_HI_OFS);
                w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (char_ready) begin
                    if (wr_req) begin
                        w_state_nxt = ST_WR_LO;
                    end else if (r_char_last) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_FETCH_LO;
                    end
                end
            end
            ST_WR_LO: begin
                bram_en     = 1'b1;
                bram_we     = 1'b1;
                bram_addr   = w_wr_base + ADDR_W'(NIB_LO_OFS);
                bram_di     = wr_char[3:0];
                w_state_nxt = ST_WR_HI;
            end
            ST_WR_HI: begin
                bram_en     = 1'b1;
                bram_we     = 1'b1;
                bram_addr   = w_wr_base + ADDR_W'(NIB_HI_OFS);
                bram_di     = wr_char[7:4];
                wr_ack      = 1'b1;
                w_state_nxt = (r_busy | w_accept) ? ST_FETCH_LO : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_k          <= '0;
            r_busy       <= 1'b0;
            r_char_data  <= 8'h00;
            r_char_idx   <= '0;
            r_char_last  <= 1'b0;
            r_char_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_busy <= 1'b1;
                r_k    <= '0;
            end else if (w_hshake) begin
                if (r_char_last) begin
                    r_busy <= 1'b0;
                end else begin
                    r_k <= r_k + IDX_W'(1);
                end
            end

            // BRAM read data trails the address by one cycle
            case (r_state)
                ST_FETCH_HI: begin
                    r_char_data[3:0] <= bram_do;
                end
                ST_CAPTURE: begin
                    r_char_data[7:4] <= bram_do;
                    r_char_valid     <= 1'b1;
                    r_char_idx       <= r_k;
                    r_char_last      <= w_last;
                end
                ST_PRESENT: begin
                    if (char_ready) begin
                        r_char_valid <= 1'b0;
                        r_char_last  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign char_data  = r_char_data;
    assign char_idx   = r_char_idx;
    assign char_last  = r_char_last;
    assign char_valid = r_char_valid;
    assign bram_ssr   = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_lcd_text_sequencer.sv
//==============================================================================
// Module  : tb_lcd_text_sequencer
// Brief   : Scoreboard bench for lcd_text_sequencer with a behavioural BRAM.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lcd_text_sequencer;

    localparam int NUM    = 32;
    localparam int ADDR_W = 12;
    localparam int BASE   = 0;

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b0;
    logic              start      = 1'b0;
    logic              char_ready = 1'b0;
    logic              wr_req     = 1'b0;
    logic [4:0]        wr_idx     = 5'd0;
    logic [7:0]        wr_char    = 8'h00;
    logic [3:0]        bram_do    = 4'h0;
    logic              busy;
    logic [7:0]        char_data;
    logic [4:0]        char_idx;
    logic              char_last;
    logic              char_valid;
    logic              wr_ack;
    logic [ADDR_W-1:0] bram_addr;
    logic [3:0]        bram_di;
    logic              bram_en;
    logic              bram_we;
    logic              bram_ssr;

    lcd_text_sequencer #(
        .NUM_CHARS (NUM),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .char_data  (char_data),
        .char_idx   (char_idx),
        .char_last  (char_last),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .wr_req     (wr_req),
        .wr_idx     (wr_idx),
        .wr_char    (wr_char),
        .wr_ack     (wr_ack),
        .bram_addr  (bram_addr),
        .bram_di    (bram_di),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_ssr   (bram_ssr),
        .bram_do    (bram_do)
    );

    always #5 clk = ~clk;

    // Synchronous 4Kx4 BRAM
    logic [3:0] mem [0:4095];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_di;
            bram_do <= mem[bram_addr];
        end
    end

    typedef struct { int idx; int data; bit last; } exp_t;
    typedef struct { int addr_lo; int di_lo; int di_hi; } wexp_t;

    exp_t       exp_q[$];
    wexp_t      wr_q[$];
    logic [7:0] ref_chars [NUM];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    function automatic logic [7:0] default_char(input int i);
        if (i < 16) return 8'(8'h41 + i);
        if (i < 31) return 8'(8'h61 + i - 16);
        return 8'h7C;
    endfunction

    // Ready driver: random, always-ready, or a forced stall at one index
    bit rand_ready = 1'b0;
    int stall_left = 0;
    int stall_idx  = 0;
    always begin
        @(posedge clk); #1;
        if (stall_left > 0 && char_valid && int'(char_idx) == stall_idx) begin
            char_ready = 1'b0;
            stall_left--;
        end else if (rand_ready) begin
            char_ready = ($urandom_range(0, 3) != 0);
        end else begin
            char_ready = 1'b1;
        end
    end

    // Monitor: character handshakes, stall stability, BRAM write pairs
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic [4:0]  prev_idx;
    logic        busy_chk   = 1'b0;
    logic        busy_exp;
    logic        have_lo    = 1'b0;
    logic [11:0] lo_addr;
    logic [3:0]  lo_di;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
            busy_chk   = 1'b0;
            have_lo    = 1'b0;
        end else begin
            if (busy_chk) begin
                check("busy_after_handshake", 32'(busy), 32'(busy_exp));
                busy_chk = 1'b0;
            end
            if (prev_stall) begin
                check("stall_data", 32'(char_data), 32'(prev_data));
                check("stall_idx", 32'(char_idx), 32'(prev_idx));
                check("stall_valid", 32'(char_valid), 32'd1);
                check("stall_bram_en", 32'(bram_en), 32'd0);
            end
            if (char_valid && char_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_char: got idx %0d data 0x%0h, expected no character", char_idx, char_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("char_idx", 32'(char_idx), 32'(e.idx));
                    check("char_data", 32'(char_data), 32'(e.data));
                    check("char_last", 32'(char_last), 32'(e.last));
                    busy_chk = 1'b1;
                    busy_exp = !e.last;
                end
            end
            prev_stall = char_valid && !char_ready;
            prev_data  = char_data;
            prev_idx   = char_idx;
            if (bram_en && bram_we) begin
                if (!wr_ack) begin
                    have_lo = 1'b1;
                    lo_addr = bram_addr;
                    lo_di   = bram_di;
                end else if (wr_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_wr_ack: got ack at addr 0x%0h, expected none", bram_addr);
                end else begin
                    wexp_t w;
                    w = wr_q.pop_front();
                    check("wr_lo_seen", 32'(have_lo), 32'd1);
                    check("wr_addr_lo", 32'(lo_addr), 32'(w.addr_lo));
                    check("wr_di_lo", 32'(lo_di), 32'(w.di_lo));
                    check("wr_addr_hi", 32'(bram_addr), 32'(w.addr_lo + 1));
                    check("wr_di_hi", 32'(bram_di), 32'(w.di_hi));
                    have_lo = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Expected frame: a write lands in this frame only if its index is
    // beyond the character after whose handshake it is issued
    task automatic push_frame(input int h, input int w, input logic [7:0] c, input bit do_wr);
        for (int i = 0; i < NUM; i++) begin
            exp_t e;
            e.idx  = i;
            e.data = (do_wr && w > h && w == i) ? int'(c) : int'(ref_chars[i]);
            e.last = (i == NUM - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_write(input int w, input logic [7:0] c);
        wexp_t x;
        x.addr_lo = (BASE + 2 * w) % 4096;
        x.di_lo   = int'(c[3:0]);
        x.di_hi   = int'(c[7:4]);
        wr_q.push_back(x);
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!wr_ack && n < 200) begin tick(); n++; end
        if (!wr_ack) begin
            n_checks++;
            $display("FAIL timeout_wr_ack: got no ack, expected ack within 200 cycles");
        end
        wr_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin tick(); n++; end
        if (busy) begin
            n_checks++;
            $display("FAIL timeout_busy: got busy=1, expected 0 within 5000 cycles");
        end
        tick(); tick();
    endtask

    task automatic run_frame(input int h, input int w, input logic [7:0] c, input bit do_wr, input bit extra_start);
        int n = 0;
        push_frame(h, w, c, do_wr);
        start = 1'b1; tick(); start = 1'b0;
        if (do_wr) begin
            while (!(char_valid && int'(char_idx) == h) && n < 5000) begin tick(); n++; end
            if (n >= 5000) begin
                n_checks++;
                $display("FAIL timeout_idx: got no idx %0d, expected it presented", h);
            end
            push_write(w, c);
            wr_idx = 5'(w); wr_char = c; wr_req = 1'b1;
            wait_ack();
            ref_chars[w] = c;
        end
        if (extra_start) begin
            repeat (20) tick();
            start = 1'b1; tick(); start = 1'b0;
        end
        wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(char_valid), 32'd0);
        check({tag, "_data"}, 32'(char_data), 32'd0);
        check({tag, "_idx"}, 32'(char_idx), 32'd0);
        check({tag, "_last"}, 32'(char_last), 32'd0);
        check({tag, "_wr_ack"}, 32'(wr_ack), 32'd0);
        check({tag, "_bram_en"}, 32'(bram_en), 32'd0);
        check({tag, "_bram_we"}, 32'(bram_we), 32'd0);
        check({tag, "_bram_addr"}, 32'(bram_addr), 32'(BASE));
        check({tag, "_bram_di"}, 32'(bram_di), 32'd0);
        check({tag, "_bram_ssr"}, 32'(bram_ssr), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int a = 0; a < 4096; a++) mem[a] = 4'h0;
        for (int i = 0; i < NUM; i++) begin
            ref_chars[i]      = default_char(i);
            mem[BASE + 2*i]   = ref_chars[i][3:0];
            mem[BASE + 2*i+1] = ref_chars[i][7:4];
        end

        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Default image, always ready
        run_frame(-1, 0, 8'h00, 1'b0, 1'b0);

        // Ten-cycle stall while idx3 is presented
        stall_idx = 3; stall_left = 10;
        run_frame(-1, 0, 8'h00, 1'b0, 1'b0);

        // Reset while the high nibble of idx7 is being fetched
        push_frame(-1, 0, 8'h00, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!(bram_en && !bram_we && bram_addr == 12'(BASE + 15)) && n < 500) begin tick(); n++; end
        if (n >= 500) begin
            n_checks++;
            $display("FAIL timeout_fetch7: got no idx7 high fetch, expected one");
        end
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        tick(); tick();
        reset_n = 1'b1;
        tick();
        run_frame(-1, 0, 8'h00, 1'b0, 1'b0);

        // Mid-frame write to a not-yet-streamed index
        run_frame(5, 20, 8'h5A, 1'b1, 1'b0);

        // Write and start in the same idle cycle
        push_write(0, 8'h2A);
        push_frame(-1, 0, 8'h2A, 1'b1);
        wr_idx = 5'd0; wr_char = 8'h2A; wr_req = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_ack();
        ref_chars[0] = 8'h2A;
        wait_idle();

        // Randomized ready and writes, including already-streamed indices
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            run_frame(int'($urandom_range(0, 30)), int'($urandom_range(0, 31)),
                      8'($urandom_range(0, 255)), 1'b1, 1'b0);
        end

        // Start while busy must not queue another frame
        run_frame(-1, 0, 8'h00, 1'b0, 1'b1);
        repeat (200) tick();

        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
